// File: rtl/change_dispense_controller.sv
// Change payout sequencer: splits a change amount greedily into coins and
// drives one-coin-at-a-time req/ack transfers to the coin hopper.
module change_dispense_controller #(
  parameter logic [6:0] COIN0_VAL   = 7'd10,
  parameter logic [6:0] COIN1_VAL   = 7'd5,
  parameter logic [6:0] COIN2_VAL   = 7'd2,
  parameter logic [6:0] COIN3_VAL   = 7'd1,
  parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       change_valid,
  input  logic [6:0] change_amount,
  output logic       change_ready,
  input  logic [3:0] hopper_empty,
  output logic       hopper_req,
  output logic [1:0] hopper_sel,
  input  logic       hopper_ack,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [6:0] remaining,
  output logic [6:0] coin_count
);

  localparam int unsigned AMT_W = 7;
  localparam int unsigned TMO_W = 8;
  localparam int unsigned SEL_W = 2;
  localparam logic [AMT_W-1:0] CNT_MAX = {AMT_W{1'b1}};

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] coin_count_q, coin_count_d;
  logic [SEL_W-1:0] hopper_sel_q, hopper_sel_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             change_ready_q, change_ready_d;
  logic             hopper_req_q, hopper_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic [3:0]       elig_c;

  function automatic logic [AMT_W-1:0] coin_value(input logic [SEL_W-1:0] idx);
    case (idx)
      2'd0:    return COIN0_VAL;
      2'd1:    return COIN1_VAL;
      2'd2:    return COIN2_VAL;
      default: return COIN3_VAL;
    endcase
  endfunction

  // A denomination is usable if its tube has coins and it does not overpay.
  assign elig_c[0] = !hopper_empty[0] && (COIN0_VAL <= remaining_q);
  assign elig_c[1] = !hopper_empty[1] && (COIN1_VAL <= remaining_q);
  assign elig_c[2] = !hopper_empty[2] && (COIN2_VAL <= remaining_q);
  assign elig_c[3] = !hopper_empty[3] && (COIN3_VAL <= remaining_q);

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_count_d = coin_count_q;
    hopper_sel_d = hopper_sel_q;
    tmo_d        = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (change_valid && change_ready_q) begin
          remaining_d  = change_amount;
          coin_count_d = '0;
          state_d      = ST_SELECT;
        end
      end
      ST_SELECT: begin
        tmo_d = '0;
        if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else if (elig_c[0]) begin
          hopper_sel_d = 2'd0;
          state_d      = ST_REQ;
        end else if (elig_c[1]) begin
          hopper_sel_d = 2'd1;
          state_d      = ST_REQ;
        end else if (elig_c[2]) begin
          hopper_sel_d = 2'd2;
          state_d      = ST_REQ;
        end else if (elig_c[3]) begin
          hopper_sel_d = 2'd3;
          state_d      = ST_REQ;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_REQ: begin
        if (hopper_ack) begin
          remaining_d = remaining_q - coin_value(hopper_sel_q);
          if (coin_count_q != CNT_MAX) begin
            coin_count_d = coin_count_q + AMT_W'(1);
          end
          state_d = ST_RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == ACK_TIMEOUT) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_RELEASE: begin
        if (!hopper_ack) begin
          state_d = ST_SELECT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered straight from the next state so they track it.
    change_ready_d = (state_d == ST_IDLE);
    busy_d         = (state_d != ST_IDLE);
    hopper_req_d   = (state_d == ST_REQ);
    done_d         = (state_d == ST_DONE);
    fault_d        = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      remaining_q    <= '0;
      coin_count_q   <= '0;
      hopper_sel_q   <= '0;
      tmo_q          <= '0;
      change_ready_q <= 1'b1;
      hopper_req_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      coin_count_q   <= coin_count_d;
      hopper_sel_q   <= hopper_sel_d;
      tmo_q          <= tmo_d;
      change_ready_q <= change_ready_d;
      hopper_req_q   <= hopper_req_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      fault_q        <= fault_d;
    end
  end

  assign change_ready = change_ready_q;
  assign hopper_req   = hopper_req_q;
  assign hopper_sel   = hopper_sel_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fault        = fault_q;
  assign remaining    = remaining_q;
  assign coin_count   = coin_count_q;

endmodule

// File: tb/tb_change_dispense_controller.sv
// Bench for change_dispense_controller: directed and random payouts scored
// against a greedy coin-breakdown model with a randomized hopper responder.
module tb_change_dispense_controller;

  localparam int ACK_TIMEOUT = 255;

  logic       clk;
  logic       rst_n;
  logic       change_valid;
  logic [6:0] change_amount;
  logic       change_ready;
  logic [3:0] hopper_empty;
  logic       hopper_req;
  logic [1:0] hopper_sel;
  logic       hopper_ack;
  logic       busy;
  logic       done;
  logic       fault;
  logic [6:0] remaining;
  logic [6:0] coin_count;

  int vectors;
  int miscompares;

  int exp_sel[$];
  int exp_rem;
  bit exp_done;

  change_dispense_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .change_ready  (change_ready),
    .hopper_empty  (hopper_empty),
    .hopper_req    (hopper_req),
    .hopper_sel    (hopper_sel),
    .hopper_ack    (hopper_ack),
    .busy          (busy),
    .done          (done),
    .fault         (fault),
    .remaining     (remaining),
    .coin_count    (coin_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Greedy breakdown: largest non-empty denomination that does not overpay.
  task automatic model_payout(input int amt, input logic [3:0] empty);
    int vals[4];
    int pick;
    vals = '{10, 5, 2, 1};
    exp_sel.delete();
    exp_rem  = amt;
    exp_done = 1'b1;
    while (exp_rem > 0) begin
      pick = -1;
      for (int i = 3; i >= 0; i--) begin
        if (!empty[i] && vals[i] <= exp_rem) pick = i;
      end
      if (pick < 0) begin
        exp_done = 1'b0;
        break;
      end
      exp_sel.push_back(pick);
      exp_rem -= vals[pick];
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(change_ready), 32'd1);
    check({tag, "_req"},   32'(hopper_req),   32'd0);
    check({tag, "_sel"},   32'(hopper_sel),   32'd0);
    check({tag, "_busy"},  32'(busy),         32'd0);
    check({tag, "_done"},  32'(done),         32'd0);
    check({tag, "_fault"}, 32'(fault),        32'd0);
    check({tag, "_rem"},   32'(remaining),    32'd0);
    check({tag, "_count"}, 32'(coin_count),   32'd0);
  endtask

  // One complete payout; reset_at>0 pulses rst_n at the rise of that coin's req.
  task automatic run_payout(input logic [6:0] amt, input logic [3:0] empty,
                            input bit no_ack, input bit poke_busy, input int reset_at);
    int cyc, req_cycles, ack_delay, hold, n_req, done_cyc;
    bit fin, got_done, got_fault, req_prev;
    model_payout(int'(amt), empty);
    @(negedge clk);
    check("ready_before_accept", 32'(change_ready), 32'd1);
    change_valid  = 1'b1;
    change_amount = amt;
    hopper_empty  = empty;
    @(negedge clk);
    change_valid  = 1'b0;
    change_amount = 7'($urandom_range(0, 127));
    check("busy_after_accept", 32'(busy), 32'd1);
    check("remaining_latched", 32'(remaining), 32'(amt));
    check("count_cleared", 32'(coin_count), 32'd0);
    cyc = 1; fin = 0; got_done = 0; got_fault = 0; req_prev = 0;
    n_req = 0; req_cycles = 0; ack_delay = 0; hold = 0; done_cyc = 0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      change_valid = 1'b0;
      if (done || fault) begin
        fin = 1; got_done = done; got_fault = fault; done_cyc = cyc;
      end else if (hopper_req) begin
        if (!req_prev) begin
          n_req++;
          if (reset_at == n_req) begin
            #2 rst_n = 1'b0;
            #1;
            check_reset_values("async_reset");
            hopper_ack = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
          end
          req_cycles = 0;
          ack_delay  = $urandom_range(0, 3);
          hold       = $urandom_range(0, 2);
          if (n_req <= exp_sel.size())
            check("hopper_sel", 32'(hopper_sel), 32'(exp_sel[n_req-1]));
          else
            check("unexpected_req", 32'(n_req), 32'(exp_sel.size()));
          if (poke_busy && n_req == 1) begin
            check("ready_low_while_busy", 32'(change_ready), 32'd0);
            change_valid  = 1'b1;
            change_amount = 7'd99;
          end
        end
        req_cycles++;
        if (!no_ack && req_cycles > ack_delay) hopper_ack = 1'b1;
      end else if (hopper_ack) begin
        if (hold == 0) hopper_ack = 1'b0;
        else hold--;
      end
      req_prev = hopper_req;
    end
    hopper_ack = 1'b0;
    check("payout_terminated", 32'(fin), 32'd1);
    if (no_ack) begin
      check("timeout_fault", 32'(got_fault), 32'd1);
      check("timeout_req_cycles", 32'(req_cycles), 32'(ACK_TIMEOUT));
      check("timeout_n_req", 32'(n_req), 32'd1);
      check("timeout_remaining", 32'(remaining), 32'(amt));
      check("timeout_count", 32'(coin_count), 32'd0);
    end else begin
      check("done_pulse", 32'(got_done), 32'(exp_done));
      check("fault_pulse", 32'(got_fault), 32'(!exp_done));
      check("coins_requested", 32'(n_req), 32'(exp_sel.size()));
      check("final_remaining", 32'(remaining), 32'(exp_rem));
      check("final_count", 32'(coin_count), 32'(exp_sel.size()));
      if (amt == 7'd0) check("zero_done_latency", 32'(done_cyc), 32'd2);
    end
    @(negedge clk);
    check("pulse_one_cycle", 32'({done, fault}), 32'd0);
    check("back_to_idle", 32'({change_ready, busy}), 32'b10);
    check("remaining_held", 32'(remaining), no_ack ? 32'(amt) : 32'(exp_rem));
    check("count_held", 32'(coin_count), no_ack ? 32'd0 : 32'(exp_sel.size()));
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    change_valid  = 1'b0;
    change_amount = 7'd0;
    hopper_empty  = 4'd0;
    hopper_ack    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    run_payout(7'd35, 4'b0000, 1'b0, 1'b0, 0);
    run_payout(7'd0,  4'b0000, 1'b0, 1'b0, 0);
    run_payout(7'd25, 4'b0001, 1'b0, 1'b0, 0);
    run_payout(7'd7,  4'b1110, 1'b0, 1'b0, 0);
    run_payout(7'd20, 4'b0000, 1'b1, 1'b0, 0);
    run_payout(7'd30, 4'b0000, 1'b0, 1'b1, 0);
    run_payout(7'd30, 4'b0000, 1'b0, 1'b0, 2);
    check_reset_values("after_reset");
    run_payout(7'd10, 4'b0000, 1'b0, 1'b0, 0);
    run_payout(7'd127, 4'b0111, 1'b0, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      run_payout(7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
